// File: rtl/ps2_packet_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 packet sequencer.
//               Holds the sequencer state encoding and the byte/packet
//               geometry used by the interface, the top and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int PS2_BYTE_W    = 8;
    localparam int PS2_SYNC_BIT  = 3;
    localparam int PS2_MAX_BYTES = 4;
    localparam int PS2_PKT_W     = PS2_MAX_BYTES * PS2_BYTE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_packet_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_packet_ctrl_if
// Description : Byte-in / packet-out bundle of the PS/2 packet sequencer.
//               master : byte source + packet consumer (drives rx_*, ready)
//               slave  : the sequencer (drives packet, status and errors)
//   rx_tick     1  one-cycle strobe qualifying rx_data
//   rx_data     8  received byte
//   pkt_ready   1  consumer accepts the presented packet
//   pkt_valid   1  packet available
//   pkt_data   32  packet, byte0 in [31:24], unused bytes zero
//   byte_index  3  bytes stored in the current packet
//   busy        1  sequencer is collecting or holding
//   err_*       1  one-cycle error pulses (sync / timeout / overrun)
//   drop_count  8  saturating count of error events
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_packet_ctrl_if;
    import ps2_pkg::*;

    logic                  rx_tick;
    logic [PS2_BYTE_W-1:0] rx_data;
    logic                  pkt_ready;
    logic                  pkt_valid;
    logic [PS2_PKT_W-1:0]  pkt_data;
    logic [2:0]            byte_index;
    logic                  busy;
    logic                  err_sync;
    logic                  err_timeout;
    logic                  err_overrun;
    logic [7:0]            drop_count;

    modport master (
        output rx_tick, rx_data, pkt_ready,
        input  pkt_valid, pkt_data, byte_index, busy,
               err_sync, err_timeout, err_overrun, drop_count
    );

    modport slave (
        input  rx_tick, rx_data, pkt_ready,
        output pkt_valid, pkt_data, byte_index, busy,
               err_sync, err_timeout, err_overrun, drop_count
    );

endinterface
`default_nettype wire

// File: rtl/ps2_packet_ctrl_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_gap_timer
// Description : Inter-byte gap timer. Counts idle cycles while enabled and
//               flags expiry on the cycle whose increment would bring the
//               count to TIMEOUT_CYCLES-1, so the owner can act on the same
//               clock edge. A clear always dominates.
//   clk        1  clock, rising edge
//   rst_n      1  asynchronous active-low reset
//   i_clear    1  synchronous clear of the count
//   i_enable   1  count this cycle
//   o_expire   1  gap limit reached this cycle (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    localparam int            c_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CYCLES - 2);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable & (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ps2_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_packet_ctrl
// Description : PS/2 multi-byte packet sequencer. Frames received bytes into
//               BYTES-long packets, rejects first bytes lacking the sync bit,
//               discards stalled partial packets after an inter-byte timeout
//               and presents whole packets under a valid/ready handshake.
//   clk    1  clock, rising edge
//   rst_n  1  asynchronous active-low reset
//   bus       ps2_packet_ctrl_if.slave (byte input, packet output, status)
// Parameters:
//   BYTES          packet length 1..4
//   TIMEOUT_CYCLES inter-byte gap limit in cycles, >= 2
//   SYNC_CHECK     1: first byte must carry bit 3 set
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_packet_ctrl
    import ps2_pkg::*;
#(
    parameter int BYTES          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit SYNC_CHECK     = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ps2_packet_ctrl_if.slave bus
);

    localparam logic [2:0] c_BYTES = 3'(BYTES);

    state_t                r_state,       w_state_next;
    logic                  r_pkt_valid,   w_pkt_valid_next;
    logic [PS2_PKT_W-1:0]  r_pkt_data,    w_pkt_data_next;
    logic [2:0]            r_byte_index,  w_byte_index_next;
    logic                  r_busy,        w_busy_next;
    logic                  r_err_sync,    w_err_sync_next;
    logic                  r_err_timeout, w_err_timeout_next;
    logic                  r_err_overrun, w_err_overrun_next;
    logic [7:0]            r_drop_count,  w_drop_count_next;

    logic w_accept;
    logic w_sync_bad;
    logic w_take_first;
    logic w_timer_en;
    logic w_timer_clear;
    logic w_expire;

    // pkt_valid is only ever high in HOLD, so this is the whole handshake.
    assign w_accept   = r_pkt_valid & bus.pkt_ready;
    assign w_sync_bad = SYNC_CHECK & ~bus.rx_data[PS2_SYNC_BIT];
    // A byte is a packet-start candidate in IDLE, and also in HOLD when the
    // held packet leaves on this very edge (back-to-back packets).
    assign w_take_first = bus.rx_tick &
                          ((r_state == IDLE) | ((r_state == HOLD) & w_accept));

    assign w_timer_en    = (r_state == COLLECT);
    assign w_timer_clear = bus.rx_tick | ~w_timer_en;

    ps2_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pkt_valid   <= 1'b0;
            r_pkt_data    <= '0;
            r_byte_index  <= '0;
            r_busy        <= 1'b0;
            r_err_sync    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pkt_valid   <= w_pkt_valid_next;
            r_pkt_data    <= w_pkt_data_next;
            r_byte_index  <= w_byte_index_next;
            r_busy        <= w_busy_next;
            r_err_sync    <= w_err_sync_next;
            r_err_timeout <= w_err_timeout_next;
            r_err_overrun <= w_err_overrun_next;
            r_drop_count  <= w_drop_count_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pkt_valid_next   = r_pkt_valid;
        w_pkt_data_next    = r_pkt_data;
        w_byte_index_next  = r_byte_index;
        w_err_sync_next    = 1'b0;
        w_err_timeout_next = 1'b0;
        w_err_overrun_next = 1'b0;
        w_drop_count_next  = r_drop_count;

        case (r_state)
            COLLECT: begin
                // A tick on the expiry cycle wins over the timeout.
                if (bus.rx_tick) begin
                    for (int i = 0; i < PS2_MAX_BYTES; i++) begin
                        if (r_byte_index == 3'(i)) begin
                            w_pkt_data_next[(PS2_MAX_BYTES-1-i)*PS2_BYTE_W +: PS2_BYTE_W] = bus.rx_data;
                        end
                    end
                    w_byte_index_next = r_byte_index + 3'd1;
                    if ((r_byte_index + 3'd1) == c_BYTES) begin
                        w_state_next     = HOLD;
                        w_pkt_valid_next = 1'b1;
                    end
                end else if (w_expire) begin
                    w_err_timeout_next = 1'b1;
                    w_pkt_data_next    = '0;
                    w_byte_index_next  = '0;
                    w_state_next       = IDLE;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    // pkt_data deliberately keeps the accepted packet.
                    w_pkt_valid_next  = 1'b0;
                    w_byte_index_next = '0;
                    w_state_next      = IDLE;
                end else if (bus.rx_tick) begin
                    w_err_overrun_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_take_first) begin
            if (w_sync_bad) begin
                w_err_sync_next = 1'b1;
            end else begin
                w_pkt_data_next   = {bus.rx_data, {(PS2_PKT_W-PS2_BYTE_W){1'b0}}};
                w_byte_index_next = 3'd1;
                if (BYTES == 1) begin
                    w_state_next     = HOLD;
                    w_pkt_valid_next = 1'b1;
                end else begin
                    w_state_next = COLLECT;
                end
            end
        end

        // The error sources are mutually exclusive per cycle, so one
        // increment covers every event.
        if ((w_err_sync_next | w_err_timeout_next | w_err_overrun_next) &&
            (r_drop_count != 8'hFF)) begin
            w_drop_count_next = r_drop_count + 8'd1;
        end

        w_busy_next = (w_state_next != IDLE);
    end

    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.pkt_data    = r_pkt_data;
    assign bus.byte_index  = r_byte_index;
    assign bus.busy        = r_busy;
    assign bus.err_sync    = r_err_sync;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_overrun = r_err_overrun;
    assign bus.drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: doc/ps2_packet_ctrl.md
Name: ps2_packet_ctrl

Overview:
- Sequencer for PS/2 multi-byte packet assembly.
- Sits between the PS/2 byte receiver (rx_tick + rx_data) and packet consumers (mouse/keyboard decoders).
- Frames bytes into fixed-length packets, checks the first-byte sync bit and aborts stalled packets on an inter-byte timeout.
- Presents each complete packet as a 32-bit word under a valid/ready handshake, and counts dropped bytes/packets.

Parameters:
- BYTES, 4, packet length in bytes, legal 1..4.
- TIMEOUT_CYCLES, 100000, max clk cycles allowed between consecutive bytes of one packet, legal >= 2.
- SYNC_CHECK, 1, when 1 the first byte must have bit[3]=1 (PS/2 mouse always-one bit); when 0 there is no check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_tick  input  1  one-cycle strobe; rx_data is valid for this cycle.
- rx_data  input  8  received byte.
- pkt_ready  input  1  consumer accepts the packet.
- pkt_valid  output  1  packet available.
- pkt_data  output  32  packet; byte0 at [31:24], byte1 at [23:16], byte2 at [15:8], byte3 at [7:0]; unused bytes are 0.
- byte_index  output  3  number of bytes stored in the current packet (0..BYTES).
- busy  output  1  high in COLLECT or HOLD.
- err_sync  output  1  one-cycle pulse: first byte rejected.
- err_timeout  output  1  one-cycle pulse: partial packet discarded.
- err_overrun  output  1  one-cycle pulse: byte lost while holding.
- drop_count  output  8  saturating count of all err_* events.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE.
  - pkt_valid=0, pkt_data=0, byte_index=0, busy=0, all err_* = 0, drop_count=0, timer=0.
- All other logic is synchronous to the rising edge of clk. All outputs are registered.
- IDLE:
  - On rx_tick with SYNC_CHECK=1 and rx_data[3]=0: err_sync=1 next cycle; drop_count+1; stay IDLE.
  - On any other rx_tick: store rx_data into [31:24], clear the lower bytes, byte_index=1, timer=0.
  - Then go to HOLD if BYTES=1, otherwise go to COLLECT.
- COLLECT:
  - On rx_tick: store rx_data into byte slot byte_index, increment byte_index, clear timer.
  - When byte_index reaches BYTES, go to HOLD.
  - With no rx_tick, the timer increments each cycle.
  - When the timer reaches TIMEOUT_CYCLES-1 without a tick: err_timeout pulse; drop_count+1; pkt_data cleared; byte_index=0; go to IDLE.
  - If rx_tick arrives in the same cycle the timer expires, the tick wins and no timeout occurs.
- HOLD:
  - pkt_valid=1; pkt_data and byte_index stay stable until handshake.
  - pkt_valid rises on the clock edge that stores the final byte, so it is visible the cycle after the final rx_tick.
  - Handshake is pkt_valid & pkt_ready: next cycle pkt_valid=0, byte_index=0, state IDLE. pkt_data keeps its last value.
  - rx_tick without handshake: byte discarded; err_overrun pulse; drop_count+1; stay HOLD.
  - rx_tick in the same cycle as handshake: the byte is processed exactly as an IDLE arrival (sync check applied). It may start the next packet immediately, with no overrun flagged.
- pkt_ready is ignored while pkt_valid=0.
- drop_count saturates at 255 and never wraps.
- Two err_* events can never occur in the same cycle.
- busy = (state != IDLE).
- Timer width is clog2(TIMEOUT_CYCLES); the timer runs only in COLLECT.

Decomposition:
- Shared package ps2_pkg:
  - State enum {IDLE, COLLECT, HOLD}.
  - Constant PS2_BYTE_W=8.
  - Constant PS2_SYNC_BIT=3.
  - Constant PS2_MAX_BYTES=4.
- Sub-module ps2_gap_timer (clear, enable, expire at TIMEOUT_CYCLES-1), instantiated once.
- FSM, byte packing and counters stay in the top module.

Test Plan:
- BYTES=4, pkt_ready=1; ticks with 0x09, 0x12, 0x34, 0x56, 5 cycles apart -> pkt_valid high for exactly one cycle, starting the cycle after the 4th tick; pkt_data=0x09123456; drop_count=0.
- First byte 0x00 (bit3=0) -> err_sync pulse; drop_count=1; state IDLE. Then 0x08, 0xAA, 0xBB, 0xCC -> pkt_data=0x08AABBCC.
- TIMEOUT_CYCLES=16; send 0x08, 0x11, then idle 20 cycles -> err_timeout exactly 15 cycles after the 2nd tick; byte_index=0; drop_count=1. A tick landing on the expiry cycle instead yields no timeout.
- pkt_ready=0 after a full packet 0x08010203; extra tick 0xFF -> err_overrun; pkt_data still 0x08010203. Raise pkt_ready with a simultaneous tick 0x18 -> packet accepted; byte_index=1; new [31:24]=0x18.
- BYTES=3 -> packet 0x08A1B2 appears as pkt_data=0x08A1B200. BYTES=1 -> pkt_valid the cycle after a single 0x0F tick.
- Assert reset mid-COLLECT (byte_index=2) -> all outputs 0 asynchronously. 300 forced errors -> drop_count holds at 255.
